approx_sklansky_pipe: RTL and testbench
=======================================

Name: approx_sklansky_pipe

Overview:
Parametrised, pipelined Sklansky prefix adder with a per-transaction approximation depth K.
- The low K bits use generate-only carries: no carry propagation, and carry-in is ignored.
- The upper WIDTH-K bits are exact prefix logic, seeded by the generate of bit K-1.
- K=0 gives an exact adder.
- Valid/ready streaming datapath for the approximate-arithmetic PPA/accuracy exploration flow.

Parameters:
- WIDTH, 16: operand width; power of two, 4..64.
- K_MAX, 8: largest approximation depth supported; must be less than WIDTH.
- KW, $clog2(K_MAX+1): width of the k port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts the beat
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Carry_in  in  1  carry-in; used only when k==0
- k  in  KW  approximation depth for this beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- Sum  out  WIDTH  result sum
- Carry_Out  out  1  carry out of the MSB
- err_dist  out  WIDTH+1  |exact - approximate|, meaningful only with ERR_MON_EN
- err_count  out  32  count of results with err_dist != 0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst); these are fixed.
- Reset values: all pipeline valid bits 0, out_valid=0, Sum=0, Carry_Out=0, err_dist=0, err_count=0.
- Reset mid-operation drops all in-flight beats; no output is produced for them.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. The pipeline advances as one unit; there is no bubble collapsing.
  - While stalled, all stage registers and outputs hold.
  - Accept and output transfer in the same cycle is legal and keeps full throughput (1 beat/cycle).
- Latency: L = $clog2(WIDTH)+2 cycles from acceptance to out_valid (6 for WIDTH=16).
  - Stage 0 registers p=A^B, g=A&B, k and Carry_in.
  - Stages 1..$clog2(WIDTH) are Sklansky prefix levels: at level j, bits whose index has bit j-1 set combine with the group ending at the nearest lower block boundary.
  - The last stage forms Sum and Carry_Out.
- k travels with its beat. A k value greater than K_MAX is clamped to K_MAX.
- Arithmetic, with bit indices 0-based and c[i] the carry out of bit i:
  - k=0: exact. c[-1]=Carry_in, c[i]=G[0..i] | P[0..i]&Carry_in.
  - k>=1, for i<k: c[i]=g[i]. Sum[0]=p[0], Sum[i]=p[i]^g[i-1] for 1<=i<k.
  - k>=1, for i>=k: c[i]=G[k..i] | P[k..i]&g[k-1], and Sum[i]=p[i]^c[i-1].
  - Carry_Out=c[WIDTH-1].
  - Group terms G[a..b] and P[a..b] come from the prefix tree. Masking to k is applied in the final stage, so the tree is shared by every k.

Optional Feature:
- APPROX_ERR_MON_EN defined:
  - A parallel exact sum {Carry_Out,Sum} with Carry_in is pipelined alongside the datapath.
  - err_dist is registered with out_valid.
  - err_count increments, saturating at 2^32-1, on each output transfer with err_dist != 0.
- APPROX_ERR_MON_EN undefined: err_dist and err_count are tied to 0 and no monitor logic is instantiated.

Decomposition:
- Package approx_adder_pkg holds:
  - the typedef pg_t as a struct {logic p; logic g;};
  - the function pg_combine(hi, lo), returning {hi.p&lo.p, hi.g|hi.p&lo.g};
  - the constant PREFIX_LEVELS(width).
- One sub-module is natural: prefix_pg_cell, a combinational black cell wrapping pg_combine and instanced in each prefix level.

Test Plan:
- WIDTH=16, k=0, A=0xFFFF, B=0x0001, Carry_in=0 -> after 6 cycles Sum=0x0000, Carry_Out=1; err_dist=0.
- k=8, A=0x00FF, B=0x0001 -> Sum=0x00FC, Carry_Out=0. With APPROX_ERR_MON_EN: err_dist=4, err_count=1.
- k=8, A=0x8080, B=0x8080, Carry_in=1 -> Sum=0x0100, Carry_Out=1; Carry_in is ignored, so err_dist=1.
- Back-to-back beats with k cycling 0,3,8,15 (15 clamps to 8), out_ready toggling 1010 -> results in order, each held stable while out_valid && !out_ready, no loss or duplication, 1 beat/cycle when out_ready=1.
- Four beats in flight, rst asserted for 1 cycle -> next cycle out_valid=0 and err_count=0; the first beat after reset emerges exactly L cycles after its acceptance.
- Random A, B, k against a reference model implementing the formulas above for 10k beats -> bit-exact Sum/Carry_Out match; err_dist matches |exact - approximate|.

Source files
------------

// File: rtl/approx_sklansky_pipe_pkg.sv
// Shared propagate/generate type, black-cell combine function and prefix depth helper
// for the approximate Sklansky adder pipeline.
package approx_adder_pkg;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
      pg_t r;
      r.p = hi.p & lo.p;
      r.g = hi.g | (hi.p & lo.g);
      return r;
   endfunction

   function automatic int PREFIX_LEVELS(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/prefix_pg_cell.sv
// Combinational Sklansky black cell: merges a higher group with the adjacent lower group.
// Zero latency, no handshake.
module prefix_pg_cell
   import approx_adder_pkg::*;
(
   input  pg_t hi,
   input  pg_t lo,
   output pg_t grp
);

   assign grp = pg_combine(hi, lo);

endmodule

// File: rtl/approx_sklansky_pipe.sv
// Pipelined Sklansky adder with per-beat approximation depth k; APPROX_ERR_MON_EN adds the error monitor.
// Latency $clog2(WIDTH)+2; in_ready = !out_valid || out_ready, the whole pipe stalls as one unit.
module approx_sklansky_pipe
   import approx_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int K_MAX = 8,
   parameter int KW    = $clog2(K_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Carry_in,
   input  logic [KW-1:0]    k,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry_Out,
   output logic [WIDTH:0]   err_dist,
   output logic [31:0]      err_count
);

   localparam int               LEVELS = PREFIX_LEVELS(WIDTH);
   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

   logic          advance;
   logic [KW-1:0] k_clamped;

   assign in_ready  = !out_valid || out_ready;
   assign advance   = in_ready;
   assign k_clamped = (k > KW'(K_MAX)) ? KW'(K_MAX) : k;

   // Raw operand terms ride alongside the tree; the final stage needs them for low-bit sums.
   logic             st_vld [0:LEVELS];
   logic [WIDTH-1:0] st_p   [0:LEVELS];
   logic [WIDTH-1:0] st_g   [0:LEVELS];
   logic [KW-1:0]    st_k   [0:LEVELS];
   logic             st_cin [0:LEVELS];

   logic [WIDTH-1:0] tr_p      [1:LEVELS];
   logic [WIDTH-1:0] tr_g      [1:LEVELS];
   logic [WIDTH-1:0] lvl_in_p  [1:LEVELS];
   logic [WIDTH-1:0] lvl_in_g  [1:LEVELS];
   logic [WIDTH-1:0] lvl_out_p [1:LEVELS];
   logic [WIDTH-1:0] lvl_out_g [1:LEVELS];

   // Tree input: bits below k-1 are killed and bit k-1 becomes a pure generate seed,
   // so the plain prefix G[0..i] equals G[k..i] | P[k..i]&g[k-1]; for k=0 Carry_in folds into bit 0.
   logic [WIDTH-1:0] low_mask0;
   logic [WIDTH-1:0] seed_mask0;
   logic [WIDTH-1:0] tin_p;
   logic [WIDTH-1:0] tin_g;
   logic             cin_fold;

   always_comb begin
      low_mask0  = (ONE << st_k[0]) - ONE;
      seed_mask0 = (ONE << st_k[0]) >> 1;
      cin_fold   = (st_k[0] == '0) && st_cin[0] && st_p[0][0];
      tin_p      = st_p[0] & ~low_mask0;
      tin_g      = (st_g[0] & (~low_mask0 | seed_mask0)) | {{(WIDTH-1){1'b0}}, cin_fold};
   end

   assign lvl_in_p[1] = tin_p;
   assign lvl_in_g[1] = tin_g;

   for (genvar j = 2; j <= LEVELS; j++) begin : g_link
      assign lvl_in_p[j] = tr_p[j-1];
      assign lvl_in_g[j] = tr_g[j-1];
   end

   for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (((i >> (j - 1)) % 2) == 1) begin : g_black
            localparam int LO = ((i >> (j - 1)) << (j - 1)) - 1;
            pg_t hi_pg;
            pg_t lo_pg;
            pg_t grp_pg;
            assign hi_pg = '{p: lvl_in_p[j][i],  g: lvl_in_g[j][i]};
            assign lo_pg = '{p: lvl_in_p[j][LO], g: lvl_in_g[j][LO]};
            prefix_pg_cell u_cell (
               .hi  (hi_pg),
               .lo  (lo_pg),
               .grp (grp_pg)
            );
            assign lvl_out_p[j][i] = grp_pg.p;
            assign lvl_out_g[j][i] = grp_pg.g;
         end else begin : g_pass
            assign lvl_out_p[j][i] = lvl_in_p[j][i];
            assign lvl_out_g[j][i] = lvl_in_g[j][i];
         end
      end
   end

   // Final stage: bits below k take their own generate as carry, the rest take the tree carry.
   logic [WIDTH-1:0] low_mask_f;
   logic [WIDTH-1:0] carry_f;
   logic             cin_f;
   logic [WIDTH-1:0] fin_sum;
   logic             fin_co;

   always_comb begin
      low_mask_f = (ONE << st_k[LEVELS]) - ONE;
      carry_f    = (st_g[LEVELS] & low_mask_f) | (tr_g[LEVELS] & ~low_mask_f);
      cin_f      = (st_k[LEVELS] == '0) && st_cin[LEVELS];
      fin_sum    = st_p[LEVELS] ^ {carry_f[WIDTH-2:0], cin_f};
      fin_co     = carry_f[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s <= LEVELS; s++) begin
            st_vld[s] <= 1'b0;
         end
         out_valid <= 1'b0;
         Sum       <= '0;
         Carry_Out <= 1'b0;
      end else if (advance) begin
         st_vld[0] <= in_valid;
         st_p[0]   <= A ^ B;
         st_g[0]   <= A & B;
         st_k[0]   <= k_clamped;
         st_cin[0] <= Carry_in;
         for (int s = 1; s <= LEVELS; s++) begin
            st_vld[s] <= st_vld[s-1];
            st_p[s]   <= st_p[s-1];
            st_g[s]   <= st_g[s-1];
            st_k[s]   <= st_k[s-1];
            st_cin[s] <= st_cin[s-1];
         end
         out_valid <= st_vld[LEVELS];
         if (st_vld[LEVELS]) begin
            Sum       <= fin_sum;
            Carry_Out <= fin_co;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         for (int j = 1; j <= LEVELS; j++) begin
            tr_p[j] <= lvl_out_p[j];
            tr_g[j] <= lvl_out_g[j];
         end
      end
   end

`ifdef APPROX_ERR_MON_EN
   logic [WIDTH:0] st_exact [0:LEVELS];
   logic [WIDTH:0] approx_f;
   logic [WIDTH:0] fin_err;

   always_comb begin
      approx_f = {fin_co, fin_sum};
      fin_err  = (st_exact[LEVELS] >= approx_f) ? (st_exact[LEVELS] - approx_f)
                                                : (approx_f - st_exact[LEVELS]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_dist  <= '0;
         err_count <= '0;
      end else begin
         if (advance) begin
            st_exact[0] <= {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Carry_in};
            for (int s = 1; s <= LEVELS; s++) begin
               st_exact[s] <= st_exact[s-1];
            end
            if (st_vld[LEVELS]) begin
               err_dist <= fin_err;
            end
         end
         // Saturating count of delivered results that differ from the exact sum.
         if (out_valid && out_ready && (err_dist != '0) && (err_count != '1)) begin
            err_count <= err_count + 32'd1;
         end
      end
   end
`else
   assign err_dist  = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_approx_sklansky_pipe.sv
// Self-checking bench for approx_sklansky_pipe: directed table, handshake sequences, random scoreboard.
module tb_approx_sklansky_pipe;

   localparam int WIDTH = 16;
   localparam int K_MAX = 8;
   localparam int KW    = 4;
   localparam int LAT   = 6;
`ifdef APPROX_ERR_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  A;
   logic [WIDTH-1:0]  B;
   logic              Carry_in;
   logic [KW-1:0]     k;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  Sum;
   logic              Carry_Out;
   logic [WIDTH:0]    err_dist;
   logic [31:0]       err_count;

   always #5 clk = ~clk;

   approx_sklansky_pipe #(.WIDTH(WIDTH), .K_MAX(K_MAX), .KW(KW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Carry_in  (Carry_in),
      .k         (k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Carry_Out (Carry_Out),
      .err_dist  (err_dist),
      .err_count (err_count)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [3:0]  k;
      logic [15:0] sum;
      logic        co;
      logic [16:0] err;
   } vec_t;

   typedef struct {
      logic [16:0] val;
      logic [16:0] err;
   } exp_t;

   int          n_vec = 0;
   int          n_err = 0;
   exp_t        sb[$];
   logic [31:0] exp_cnt;
   logic        hold_pend;
   logic [17:0] held;
   vec_t        tbl[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Low k bits: p ^ (g << 1); upper bits: ordinary addition of the shifted operands plus g[k-1].
   function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input int kk);
      int unsigned kc, mask, low, up;
      logic        gk;
      kc = (kk > K_MAX) ? K_MAX : kk;
      if (kc == 0) return 17'(32'(a) + 32'(b) + 32'(cin));
      mask = (32'd1 << kc) - 32'd1;
      low  = (32'(a ^ b) ^ (32'(a & b) << 1)) & mask;
      gk   = a[kc-1] & b[kc-1];
      up   = (32'(a) >> kc) + (32'(b) >> kc) + 32'(gk);
      return 17'((up << kc) | low);
   endfunction

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input int kk);
      exp_t        e;
      logic [16:0] exact;
      e.val = ref_add(a, b, cin, kk);
      exact = 17'(32'(a) + 32'(b) + 32'(cin));
      e.err = !MON ? 17'd0 : (exact >= e.val) ? exact - e.val : e.val - exact;
      return e;
   endfunction

   // One clock cycle, entered and left at a falling edge.
   task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [3:0] kk, input logic ordy,
                       output logic acc, output logic xfer);
      exp_t e;
      in_valid  = iv;
      A         = a;
      B         = b;
      Carry_in  = ci;
      k         = kk;
      out_ready = ordy;
      #1;
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (hold_pend) chk("stall_hold", {out_valid, Carry_Out, Sum}, held);
      hold_pend = out_valid && !out_ready;
      held      = {out_valid, Carry_Out, Sum};
      if (xfer) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got sum 0x%0h, expected no result", {Carry_Out, Sum});
         end else begin
            e = sb.pop_front();
            chk("stream_sum", {Carry_Out, Sum}, e.val);
            chk("stream_err", err_dist, e.err);
            if (e.err != 0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
         end
      end
      if (acc) sb.push_back(model(a, b, ci, kk));
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      logic acc, xfer;
      int   c;
      c = 0;
      while (sb.size() != 0 && c < budget) begin
         step(1'b0, 16'h0, 16'h0, 1'b0, 4'd0, 1'b1, acc, xfer);
         c++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   task automatic single_beat(input vec_t v, input string tag);
      int lat;
      in_valid  = 1'b1;
      A         = v.a;
      B         = v.b;
      Carry_in  = v.cin;
      k         = v.k;
      out_ready = 1'b1;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      chk({tag, "_latency"}, lat, LAT);
      chk({tag, "_sum"}, {Carry_Out, Sum}, {v.co, v.sum});
      chk({tag, "_err"}, err_dist, MON ? v.err : 17'd0);
      if (MON && v.err != 0) exp_cnt++;
      @(negedge clk);
      chk({tag, "_err_count"}, err_count, exp_cnt);
   endtask

   initial begin
      logic [3:0] kseq[4];
      logic       acc, xfer;
      logic [15:0] ra, rb;
      logic        rc, riv;
      logic [3:0]  rk;
      int          sent, nx, cyc, first_x, last_x, ghost;
      exp_t        e;
      vec_t        v;

      kseq[0] = 4'd0; kseq[1] = 4'd3; kseq[2] = 4'd8; kseq[3] = 4'd15;

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 4'd0,  16'h0000, 1'b1, 17'd0};
      tbl[1] = '{16'h00FF, 16'h0001, 1'b0, 4'd8,  16'h00FC, 1'b0, 17'd4};
      tbl[2] = '{16'h8080, 16'h8080, 1'b1, 4'd8,  16'h0100, 1'b1, 17'd1};
      tbl[3] = '{16'h1234, 16'h4321, 1'b1, 4'd0,  16'h5556, 1'b0, 17'd0};
      tbl[4] = '{16'h0007, 16'h0001, 1'b0, 4'd3,  16'h0004, 1'b0, 17'd4};
      tbl[5] = '{16'h0180, 16'h0080, 1'b0, 4'd15, 16'h0200, 1'b0, 17'd0};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd1,  16'hFFFE, 1'b1, 17'd1};
      tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd0,  16'hFFFF, 1'b1, 17'd0};
      tbl[8] = '{16'h00F0, 16'h0F10, 1'b0, 4'd8,  16'h0FC0, 1'b0, 17'd64};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; Carry_in = 1'b0; k = '0;
      hold_pend = 1'b0; held = '0; exp_cnt = '0;
      repeat (3) @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_sum", {Carry_Out, Sum}, 0);
      chk("reset_err_dist", err_dist, 0);
      chk("reset_err_count", err_count, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) single_beat(tbl[i], $sformatf("tbl%0d", i));

      // Reset with four beats in flight.
      for (int i = 0; i < 4; i++)
         step(1'b1, 16'(i * 4099), 16'hF0F0, 1'b1, 4'(i), 1'b1, acc, xfer);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_err_count", err_count, 0);
      sb.delete();
      hold_pend = 1'b0;
      exp_cnt = '0;
      ghost = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) ghost++;
      end
      chk("midrst_no_ghost", ghost, 0);
      e = model(16'h3C5A, 16'h0FF7, 1'b1, 5);
      v = '{16'h3C5A, 16'h0FF7, 1'b1, 4'd5, e.val[15:0], e.val[16], e.err};
      single_beat(v, "post_rst");

      // Back-to-back beats, k cycling 0,3,8,15, out_ready toggling 1010.
      sent = 0; nx = 0; cyc = 0;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      while ((sent < 16 || sb.size() != 0) && cyc < 200) begin
         step(sent < 16, ra, rb, rc, kseq[sent % 4], (cyc % 2) == 0, acc, xfer);
         if (acc) begin
            sent++;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         end
         if (xfer) nx++;
         cyc++;
      end
      chk("bp_beats_out", nx, 16);
      drain(20);

      // Full throughput with out_ready held high.
      nx = 0; first_x = -1; last_x = -1;
      for (int c = 0; c < 8 + LAT + 4; c++) begin
         step(c < 8, 16'($urandom), 16'($urandom), 1'($urandom), 4'(c), 1'b1, acc, xfer);
         if (c < 8) chk("tput_accept", acc, 1);
         if (xfer) begin
            if (first_x < 0) first_x = c;
            last_x = c;
            nx++;
         end
      end
      chk("tput_count", nx, 8);
      chk("tput_span", last_x - first_x, 7);
      drain(20);

      // Random traffic against the reference model.
      sent = 0; cyc = 0; riv = 1'b0;
      ra = '0; rb = '0; rc = 1'b0; rk = '0;
      while (sent < 10000 && cyc < 40000) begin
         if (!riv) begin
            riv = ($urandom_range(0, 9) < 8);
            case ($urandom_range(0, 7))
               0: ra = 16'hFFFF;
               1: ra = 16'h0000;
               default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 7) == 0) ? ~ra : 16'($urandom);
            rc = 1'($urandom);
            rk = 4'($urandom_range(0, 15));
         end
         step(riv, ra, rb, rc, rk, $urandom_range(0, 9) < 7, acc, xfer);
         if (acc) begin
            sent++;
            riv = 1'b0;
         end
         cyc++;
      end
      chk("rand_beats_sent", sent, 10000);
      drain(50);
      chk("rand_err_count", err_count, exp_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
